ex16_vec_checker: RTL and testbench
===================================

Name: ex16_vec_checker

Overview:
- Synthesizable stimulus/response engine for the ex16 gate (y = (~a|~b)&(~c|~d) | ~e).
- Drives ex16 inputs exhaustively and samples the DUT output after a settle delay.
- Compares each sample against an internal golden model, counts mismatches and reports pass/fail.
- Sits across the ex16 interface from the DUT: it produces a..e and consumes y, so the gate can be self-tested on silicon or FPGA without a simulator bench.

Parameters:
- N_IN, 5: number of DUT inputs; stim vector width.
- ERR_W, 8: error counter width; the counter saturates.
- SETTLE_CYC, 1: cycles held after a new vector before sampling; minimum 1.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- stim  out  N_IN  DUT inputs {a,b,c,d,e}; a is the MSB, e is bit 0.
- dut_y  in  1  DUT output.
- busy  out  1  high during SETTLE or COMPARE.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  valid when done=1; 1 iff err_count==0.
- err_count  out  ERR_W  number of mismatches, saturating.
- first_err_valid  out  1  at least one mismatch seen this run.
- first_err_vec  out  N_IN  stim value of the first mismatch.

Behaviour:
- Reset (async assert, sync deassert):
  - state=IDLE.
  - stim, err_count and first_err_vec = 0.
  - busy, done, pass and first_err_valid = 0.
  - Reset mid-run aborts immediately and nothing is retained.
- States: IDLE, SETTLE, COMPARE, DONE.
- IDLE or DONE with start=1: stim<=0, err_count<=0, first_err_valid<=0, settle counter<=0, done<=0, next SETTLE.
- SETTLE: the settle counter increments each cycle. When it reaches SETTLE_CYC-1, go to COMPARE.
- COMPARE (exactly one cycle):
  - Compute golden(stim).
  - If dut_y != golden: err_count increments unless already all-ones. If first_err_valid==0, latch first_err_vec<=stim and set first_err_valid.
  - If stim is all-ones, go to DONE with done<=1 and pass<=(the final err_count==0, including this compare).
  - Otherwise stim<=stim+1, counter<=0, back to SETTLE.
- Timing:
  - Each vector takes SETTLE_CYC+1 cycles.
  - A full run takes 2^N_IN*(SETTLE_CYC+1) cycles from the start edge to done=1.
  - With the defaults that is 64 cycles.
- stim is registered and changes only on entry to a vector, never during SETTLE or COMPARE.
- start while busy is ignored; no restart and no effect on counters.
- X/Z on dut_y counts as a mismatch (case-inequality compare).
- Golden model: ((~a|~b)&(~c|~d)) | ~e, using stim[4]=a … stim[0]=e.
- Width rule: stim wraps only through the DONE transition; no overflow increment occurs.

Optional Feature:
- Macro: CHK_MISR_EN.
- When defined:
  - Adds output sig[15:0], a 16-bit MISR with polynomial x^16+x^14+x^13+x^11+1.
  - sig clears to 16'h0000 on reset and on start.
  - Each COMPARE shifts the register and XORs dut_y into bit 0.
  - sig is frozen in DONE.
- When undefined: the port and logic are absent; all other behaviour is identical.

Decomposition:
- Package ex16_chk_pkg holds:
  - the state enum typedef (chk_state_t);
  - the golden function ex16_golden(logic [4:0]);
  - constant MISR_POLY = 16'hB400 (Galois form).
- One sub-module, ex16_misr, holds the MISR and is instantiated only under CHK_MISR_EN.

Test Plan:
- ex16 DUT connected, defaults, start pulse -> done=1 at start+64 cycles, pass=1, err_count=0, first_err_valid=0.
- dut_y tied 0 -> err_count=25, pass=0, first_err_vec=5'b00000.
- dut_y tied 1 -> err_count=7, first_err_vec=5'b00111.
- dut_y = ~golden, ERR_W=3 -> err_count saturates at 7, first_err_vec=0, pass=0.
- Reset asserted at cycle 20 of a run, then released and start issued -> all outputs at reset values; the second run completes with pass=1 after 64 cycles.
- start pulsed again at cycle 10 of a run -> ignored, done at original start+64; with CHK_MISR_EN, two clean runs give equal sig values, and a stuck-at-0 DUT gives a different sig.

Source files
------------

// File: rtl/ex16_chk_pkg.sv
// Shared types, MISR polynomial and golden model for the ex16 vector checker.
package ex16_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_COMPARE = 2'd2,
        ST_DONE    = 2'd3
    } chk_state_t;

    // Galois form of x^16+x^14+x^13+x^11+1, right-shifting register.
    localparam logic [15:0] MISR_POLY = 16'hB400;

    // y = (~a|~b)&(~c|~d) | ~e, with v[4]=a ... v[0]=e
    function automatic logic ex16_golden(input logic [4:0] v);
        return ((~v[4] | ~v[3]) & (~v[2] | ~v[1])) | ~v[0];
    endfunction

endpackage

// File: rtl/ex16_misr.sv
// 16-bit signature register folding one DUT response bit per shift.
module ex16_misr
    import ex16_chk_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        shift,
    input  logic        din,
    output logic [15:0] sig
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig <= 16'h0000;
        end else if (clear) begin
            sig <= 16'h0000;
        end else if (shift) begin
            sig <= ({1'b0, sig[15:1]} ^ (sig[0] ? MISR_POLY : 16'h0000)) ^ {15'h0000, din};
        end
    end

endmodule

// File: rtl/ex16_vec_checker.sv
// Exhaustive stimulus/response checker for the ex16 gate.
// Optional MISR signature output enabled by defining CHK_MISR_EN.
//
// state   | meaning
// IDLE    | waiting for start after reset
// SETTLE  | vector applied, holding SETTLE_CYC cycles
// COMPARE | one cycle: sample dut_y, score, advance
// DONE    | run complete, results held until start
module ex16_vec_checker
    import ex16_chk_pkg::*;
#(
    parameter int N_IN       = 5,
    parameter int ERR_W      = 8,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [N_IN-1:0]  stim,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic             first_err_valid,
    output logic [N_IN-1:0]  first_err_vec
`ifdef CHK_MISR_EN
    ,
    output logic [15:0]      sig
`endif
);

    localparam int SET_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYC - 1);

    chk_state_t       state, state_nxt;
    logic [SET_W-1:0] set_cnt;
    logic             launch;
    logic             cmp;
    logic             golden_y;
    logic             mismatch;
    logic [ERR_W-1:0] err_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        cmp       = 1'b0;
        golden_y  = ex16_golden(stim);
        mismatch  = (dut_y !== golden_y);
        err_nxt   = err_count;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    launch    = 1'b1;
                    state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (set_cnt == SET_LAST) state_nxt = ST_COMPARE;
            end
            ST_COMPARE: begin
                cmp = 1'b1;
                if (mismatch && !(&err_count)) err_nxt = err_count + ERR_W'(1);
                state_nxt = (&stim) ? ST_DONE : ST_SETTLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stim            <= '0;
            set_cnt         <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
            first_err_vec   <= '0;
        end else if (launch) begin
            stim            <= '0;
            set_cnt         <= '0;
            err_count       <= '0;
            pass            <= 1'b0;
            first_err_valid <= 1'b0;
        end else if (state == ST_SETTLE) begin
            if (set_cnt != SET_LAST) set_cnt <= set_cnt + SET_W'(1);
        end else if (cmp) begin
            err_count <= err_nxt;
            if (mismatch && !first_err_valid) begin
                first_err_valid <= 1'b1;
                first_err_vec   <= stim;
            end
            // stim is never incremented past all-ones; the next start rewinds it
            if (&stim) begin
                pass <= (err_nxt == '0);
            end else begin
                stim    <= stim + N_IN'(1);
                set_cnt <= '0;
            end
        end
    end

    assign busy = (state == ST_SETTLE) || (state == ST_COMPARE);
    assign done = (state == ST_DONE);

`ifdef CHK_MISR_EN
    ex16_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .clear (launch),
        .shift (cmp),
        .din   (dut_y),
        .sig   (sig)
    );
`endif

endmodule

// File: tb/tb_ex16_vec_checker.sv
// Directed bench for ex16_vec_checker: table of DUT behaviours plus reset/restart sequences.
module tb_ex16_vec_checker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [4:0] stim, stim3;
    logic       dut_y, dut_y3;
    logic       busy, done, pass, fv;
    logic [7:0] err;
    logic [4:0] fvec;
    logic       busy3, done3, pass3, fv3;
    logic [2:0] err3;
    logic [4:0] fvec3;
    int         mode;
    int         n_pass = 0;
    int         n_total = 0;
`ifdef CHK_MISR_EN
    logic [15:0] sig, sig3, sig_a, sig_b;
`endif

    always #5 clk = ~clk;

    function automatic logic gold(input logic [4:0] v);
        return ((~v[4] | ~v[3]) & (~v[2] | ~v[1])) | ~v[0];
    endfunction

    // mode 0 = good gate, 1 = stuck 0, 2 = stuck 1, 3 = inverted
    always_comb begin
        dut_y = 1'b0;
        case (mode)
            0: dut_y = gold(stim);
            1: dut_y = 1'b0;
            2: dut_y = 1'b1;
            default: dut_y = ~gold(stim);
        endcase
    end
    assign dut_y3 = ~gold(stim3);

    ex16_vec_checker dut (
        .clk(clk), .reset(reset), .start(start), .stim(stim), .dut_y(dut_y),
        .busy(busy), .done(done), .pass(pass), .err_count(err),
        .first_err_valid(fv), .first_err_vec(fvec)
`ifdef CHK_MISR_EN
        , .sig(sig)
`endif
    );

    ex16_vec_checker #(.ERR_W(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .stim(stim3), .dut_y(dut_y3),
        .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
        .first_err_valid(fv3), .first_err_vec(fvec3)
`ifdef CHK_MISR_EN
        , .sig(sig3)
`endif
    );

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // n = rising edges after the start edge until done is seen
    task automatic run_vec(output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("busy_after_start", int'(busy), 1);
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    typedef struct {
        string name;
        int    mode;
        int    err;
        int    pss;
        int    fv;
        int    fvec;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int n;
        tbl[0] = '{"good",    0,  0, 1, 0, 0};
        tbl[1] = '{"stuck0",  1, 25, 0, 1, 0};
        tbl[2] = '{"stuck1",  2,  7, 0, 1, 7};
        tbl[3] = '{"invert",  3, 32, 0, 1, 0};
        mode = 0;

        repeat (3) @(negedge clk);
        chk("rst_stim", int'(stim), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_err", int'(err), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_done", int'(done), 0);

        for (int i = 0; i < 4; i++) begin
            mode = tbl[i].mode;
            run_vec(n);
            chk({tbl[i].name, "_cycles"}, n, 64);
            chk({tbl[i].name, "_done"}, int'(done), 1);
            chk({tbl[i].name, "_busy"}, int'(busy), 0);
            chk({tbl[i].name, "_err"}, int'(err), tbl[i].err);
            chk({tbl[i].name, "_pass"}, int'(pass), tbl[i].pss);
            chk({tbl[i].name, "_fv"}, int'(fv), tbl[i].fv);
            chk({tbl[i].name, "_fvec"}, int'(fvec), tbl[i].fvec);
            chk({tbl[i].name, "_sat3_err"}, int'(err3), 7);
            chk({tbl[i].name, "_sat3_pass"}, int'(pass3), 0);
            chk({tbl[i].name, "_sat3_fvec"}, int'(fvec3), 0);
            repeat (3) @(negedge clk);
            chk({tbl[i].name, "_done_held"}, int'(done), 1);
        end

        // reset part-way through a failing run
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (20) @(negedge clk);
        chk("pre_rst_err_nonzero", int'(err != 0), 1);
        reset = 1'b0;
        #1;
        chk("mid_rst_stim", int'(stim), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_fv", int'(fv), 0);
        chk("mid_rst_fvec", int'(fvec), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_pass", int'(pass), 0);
        @(negedge clk) reset = 1'b1;
        mode = 0;
        run_vec(n);
        chk("after_rst_cycles", n, 64);
        chk("after_rst_pass", int'(pass), 1);
        chk("after_rst_err", int'(err), 0);
`ifdef CHK_MISR_EN
        sig_a = sig;
`endif

        // second start mid-run must not restart
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == 10);
        end
        start = 1'b0;
        chk("restart_ign_cycles", n, 64);
        chk("restart_ign_err", int'(err), 25);
        chk("restart_ign_pass", int'(pass), 0);
`ifdef CHK_MISR_EN
        chk("misr_stuck_differs", int'(sig != sig_a), 1);
        mode = 0;
        run_vec(n);
        sig_b = sig;
        chk("misr_clean_equal", int'(sig_b), int'(sig_a));
        chk("misr_nonzero", int'(sig_b != 16'h0000), 1);
        repeat (4) @(negedge clk);
        chk("misr_frozen", int'(sig), int'(sig_b));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
